// File: rtl/dpll_pkg.sv
// Shared types and arithmetic helpers for the DPLL proportional-integral loop filter.
package dpll_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } dpll_state_e;

  // Wide enough that no supported parameter set can overflow before clamping.
  typedef logic signed [63:0] wide_t;

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input wide_t lim);
    wide_t s;
    s = a + b;
    if (s > lim) begin
      s = lim;
    end else if (s < -lim) begin
      s = -lim;
    end
    return s;
  endfunction

  function automatic wide_t clamp_u(input wide_t x, input wide_t hi);
    wide_t r;
    r = x;
    if (x < 64'sd0) begin
      r = 64'sd0;
    end else if (x > hi) begin
      r = hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/dpll_lock_detect.sv
// Run/lock counters and the ACQ/TRACK/HOLD state machine of the DPLL loop filter.
module dpll_lock_detect
  import dpll_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int RUN_MAX  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic err_pos_i,
  input  logic err_neg_i,
  input  logic qual_i,
  input  logic freeze_i,
  output logic locked_o,
  output logic boost_o
);

  localparam int RCW = $clog2(RUN_MAX + 1);
  localparam int LCW = $clog2(LOCK_CNT + 1);

  dpll_state_e    state_q, state_d;
  dpll_state_e    prev_q, prev_d;
  dpll_state_e    eff_state;
  logic [RCW-1:0] run_q, run_d;
  logic [LCW-1:0] lock_q, lock_d;
  logic           sign_q, sign_d;
  logic           err_nz;

  // While holding, behave as the state we will resume into.
  assign eff_state = (state_q == HOLD) ? prev_q : state_q;
  assign err_nz    = err_pos_i | err_neg_i;
  assign locked_o  = (eff_state == TRACK);
  assign boost_o   = (eff_state == ACQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACQ;
      prev_q  <= ACQ;
      run_q   <= '0;
      lock_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      lock_q  <= lock_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    lock_d  = lock_q;
    sign_d  = sign_q;
    if (freeze_i) begin
      if (state_q != HOLD) begin
        prev_d  = state_q;
        state_d = HOLD;
      end
    end else begin
      state_d = eff_state;
      if (qual_i) begin
        if (err_nz) begin
          if ((run_q != '0) && (sign_q == err_neg_i)) begin
            if (run_q != RCW'(RUN_MAX)) begin
              run_d = run_q + RCW'(1);
            end
          end else begin
            run_d = RCW'(1);
          end
          sign_d = err_neg_i;
        end else begin
          run_d = '0;
        end

        if (run_d == RCW'(RUN_MAX)) begin
          lock_d = '0;
        end else if (lock_q != LCW'(LOCK_CNT)) begin
          lock_d = lock_q + LCW'(1);
        end

        case (eff_state)
          ACQ:     if (lock_d == LCW'(LOCK_CNT)) state_d = TRACK;
          TRACK:   if (run_d == RCW'(RUN_MAX)) state_d = ACQ;
          default: state_d = ACQ;
        endcase
      end
    end
  end

endmodule

// File: rtl/dpll_pi_loop_filter.sv
// PI loop filter: phase-detector UP/DOWN samples in, clamped centre-offset DCO word out.
module dpll_pi_loop_filter
  import dpll_pkg::*;
#(
  parameter int OUT_W    = 16,
  parameter int INT_W    = 20,
  parameter int SHIFT_W  = 4,
  parameter int CENTER   = 2 ** (OUT_W - 1),
  parameter int LOCK_CNT = 16,
  parameter int RUN_MAX  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up,
  input  logic               down,
  input  logic               in_valid,
  input  logic               freeze,
  input  logic [SHIFT_W-1:0] kp_shift,
  input  logic [SHIFT_W-1:0] ki_shift,
  output logic [OUT_W-1:0]   ctrl_out,
  output logic               ctrl_valid,
  output logic               locked,
  output logic               int_sat
);

  localparam int    SUM_W    = ((OUT_W > INT_W) ? OUT_W : INT_W) + 2;
  localparam wide_t INT_MAX  = (wide_t'(1) <<< (INT_W - 1)) - wide_t'(1);
  localparam wide_t OUT_MAX  = (wide_t'(1) <<< OUT_W) - wide_t'(1);
  localparam wide_t CENTER_W = wide_t'(CENTER);

  logic signed [INT_W-1:0] integ_q, integ_d;
  logic [OUT_W-1:0]        ctrl_q, ctrl_d;
  logic                    valid_q;
  logic                    sat_q, sat_d;
  logic                    err_pos, err_neg, qual, boost;
  wide_t                   err_w, prop, iterm, sum;
  int                      kp_amt;

  assign err_pos = up & ~down;
  assign err_neg = down & ~up;
  assign qual    = in_valid & ~freeze;
  assign err_w   = err_pos ? 64'sd1 : (err_neg ? -64'sd1 : 64'sd0);

  dpll_lock_detect #(
    .LOCK_CNT (LOCK_CNT),
    .RUN_MAX  (RUN_MAX)
  ) u_lock (
    .clk       (clk),
    .rst_n     (rst_n),
    .err_pos_i (err_pos),
    .err_neg_i (err_neg),
    .qual_i    (qual),
    .freeze_i  (freeze),
    .locked_o  (locked),
    .boost_o   (boost)
  );

  assign integ_d = INT_W'(sat_add(wide_t'(integ_q), err_w, INT_MAX));
  assign sat_d   = (wide_t'(integ_d) == INT_MAX) || (wide_t'(integ_d) == -INT_MAX);

  // Capping the shift at SUM_W still pushes the sum past either clamp rail.
  always_comb begin
    kp_amt = int'(kp_shift) + (boost ? 1 : 0);
    if (kp_amt > SUM_W) begin
      kp_amt = SUM_W;
    end
    prop = err_w <<< kp_amt;
    if (int'(ki_shift) >= SUM_W) begin
      iterm = 64'sd0;
    end else begin
      iterm = wide_t'(integ_d) >>> ki_shift;
    end
    sum = CENTER_W + prop + iterm;
  end

  assign ctrl_d = OUT_W'(clamp_u(sum, OUT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '0;
      ctrl_q  <= OUT_W'(CENTER);
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= qual;
      if (qual) begin
        integ_q <= integ_d;
        ctrl_q  <= ctrl_d;
        sat_q   <= sat_d;
      end
    end
  end

  assign ctrl_out   = ctrl_q;
  assign ctrl_valid = valid_q;
  assign int_sat    = sat_q;

endmodule

// File: doc/dpll_pi_loop_filter.md
Name: dpll_pi_loop_filter

Overview:
- Parametrised proportional-integral loop filter for the ASIC DPLL. Sits between the phase detector (UP/DOWN pulses) and the DCO control word.
- Adds sample qualification, a saturating integrator and centre-offset output clamping.
- Adds runtime gain shifts, acquisition gain boost, a lock detector state machine and a freeze/holdover mode.

Parameters:
- OUT_W, 16, width of the unsigned DCO control word.
- INT_W, 20, width of the signed integrator (two's complement).
- SHIFT_W, 4, width of the kp_shift/ki_shift ports.
- CENTER, 2**(OUT_W-1), control word at reset and with a zero integrator.
- LOCK_CNT, 16, qualifying samples needed to declare lock.
- RUN_MAX, 4, consecutive same-sign errors that declare loss of lock.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- up  in  1  phase detector UP; sampled only when in_valid=1.
- down  in  1  phase detector DOWN; sampled only when in_valid=1.
- in_valid  in  1  sample strobe, one phase-detector sample per cycle high.
- freeze  in  1  holdover request; level-sensitive.
- kp_shift  in  SHIFT_W  proportional gain = 2**kp_shift.
- ki_shift  in  SHIFT_W  integral attenuation = 2**-ki_shift.
- ctrl_out  out  OUT_W  registered DCO control word.
- ctrl_valid  out  1  one-cycle pulse when ctrl_out updates.
- locked  out  1  high in state TRACK.
- int_sat  out  1  high while the integrator is at either rail.

Behaviour:
- Reset (async assert, sync release): ctrl_out=CENTER, ctrl_valid=0, locked=0, int_sat=0, integrator=0, lock counter=0, run counter=0, state=ACQ.
- Error: err = +1 if up&!down, -1 if down&!up, 0 otherwise (both high counts as 0). err is evaluated only when in_valid=1 and freeze=0; other cycles change nothing except ctrl_valid going low.
- Integrator: integ_next = integ + err, saturated to ±(2**(INT_W-1)-1). int_sat is registered from integ_next at the rails.
- Effective proportional shift: kp_eff = kp_shift+1 in ACQ (acquisition boost), kp_shift otherwise.
- Output sum: prop = err <<< kp_eff (signed); sum = CENTER + prop + (integ_next >>> ki_shift), arithmetic shift. Computed at width max(OUT_W,INT_W)+2, then clamped to [0, 2**OUT_W-1].
- Latency: ctrl_out and the ctrl_valid pulse appear on the edge after the qualifying in_valid cycle. Back-to-back in_valid gives one update per cycle.
- States: ACQ, TRACK, HOLD.
- Run counter: counts consecutive same-sign non-zero errors. A zero error or a sign change resets it to 1 on a non-zero err, or to 0 on err=0. It saturates at RUN_MAX.
- Lock counter: increments on each qualifying sample with run < RUN_MAX and saturates at LOCK_CNT. It clears when run reaches RUN_MAX.
- ACQ -> TRACK: lock counter reaches LOCK_CNT.
- TRACK -> ACQ: run reaches RUN_MAX; the lock counter clears on the same edge.
- Any state -> HOLD: freeze=1. Sampling is ignored; integrator, counters, ctrl_out and locked are held; ctrl_valid=0.
- HOLD -> previous state: freeze=0. The state before HOLD is stored. Counters resume from their held values, and no output update occurs until the next in_valid.
- Simultaneous freeze and in_valid: freeze wins and the sample is dropped.
- kp_shift/ki_shift changes take effect on the next qualifying sample. Shifts ≥ the sum width give 0 (ki) or a clamped output (kp).
- Reset mid-operation returns everything to the reset values immediately, regardless of state.

Decomposition:
- Shared package dpll_pkg: state enum (ACQ, TRACK, HOLD), and the functions sat_add (signed saturating add) and clamp_u (signed to unsigned clamp).
- One natural sub-module: dpll_lock_detect, containing the run counter, lock counter and state machine. Inputs: err sign, qualifying strobe, freeze. Outputs: state and locked.

Test Plan:
- Reset, no in_valid -> ctrl_out=0x8000, locked=0, ctrl_valid=0 indefinitely.
- kp_shift=2, ki_shift=4, single up sample in ACQ -> next cycle ctrl_out=0x8008 (8 prop + 0 integ), ctrl_valid pulse of 1 cycle.
- 16 samples alternating up/down -> locked=1 on the edge after the 16th sample. Then 4 consecutive up samples -> locked=0 after the 4th, proportional boost back on.
- INT_W=6, ki_shift=0, kp_shift=0, 40 up samples -> integrator stops at 31, int_sat=1 from the 31st sample, ctrl_out steady at 0x8000+31+2=0x8021.
- Locked, freeze=1 with 10 up samples -> ctrl_out, locked and integrator unchanged, no ctrl_valid. freeze=0 then one down sample -> update from the held integrator, state TRACK.
- up=down=1 valid -> err=0, ctrl_out equals CENTER + integ>>>ki_shift, lock counter increments. rst_n low mid-sequence -> immediate reset values.
